// File: rtl/width_bridge.sv
// width_bridge: valid/ready bit-stream width converter (pack, split, non-integer ratios) with last-flag zero-padded flush.
// Define WIDTH_BRIDGE_REG_RDY_EN to drop the rdy_i->rdy_o combinational path (rdy_o from registered state only).
module width_bridge #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 128,
  parameter int BUF_W = IN_W + OUT_W,
  parameter int CNT_W = $clog2(BUF_W + 1),
  parameter int VB_W  = $clog2(OUT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_i,
  input  logic [IN_W-1:0]  din,
  input  logic             last_i,
  output logic             rdy_o,
  output logic             vld_o,
  output logic [OUT_W-1:0] dout,
  output logic             last_o,
  output logic [VB_W-1:0]  vbits_o,
  input  logic             rdy_i,
  output logic [CNT_W-1:0] occ_o
);
  localparam int XW = CNT_W + 1;
  localparam logic [XW-1:0] IN_C  = XW'(IN_W);
  localparam logic [XW-1:0] OUT_C = XW'(OUT_W);
  localparam logic [XW-1:0] BUF_C = XW'(BUF_W);

  if (BUF_W < IN_W + OUT_W - 1) begin : g_buf_chk
    $error("width_bridge: BUF_W must be at least IN_W+OUT_W-1");
  end

  logic [BUF_W-1:0] buf_q, buf_d, ins;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic [XW-1:0]    cnt_x, take, rem;
  logic             out_fire, in_fire;

  // Drain is applied before insert, so a beat leaving frees room for the beat arriving.
  always_comb begin
    cnt_x    = XW'(cnt_q);
    vld_o    = (cnt_x >= OUT_C) | (flush_q & (cnt_q != '0));
    last_o   = flush_q & (cnt_x <= OUT_C) & (cnt_q != '0);
    take     = (cnt_x < OUT_C) ? cnt_x : OUT_C;
    vbits_o  = vld_o ? VB_W'(take) : '0;
    out_fire = vld_o & rdy_i;
    rem      = out_fire ? cnt_x - take : cnt_x;
`ifdef WIDTH_BRIDGE_REG_RDY_EN
    rdy_o    = !flush_q & (cnt_x + IN_C <= BUF_C);
`else
    rdy_o    = !flush_q & (rem + IN_C <= BUF_C);
`endif
    in_fire  = vld_i & rdy_o;
    ins      = BUF_W'(din) << (BUF_C - IN_C - rem);
    buf_d    = (out_fire ? buf_q << OUT_W : buf_q) | (in_fire ? ins : '0);
    cnt_d    = CNT_W'(in_fire ? rem + IN_C : rem);
    flush_d  = flush_q ? !(out_fire & last_o) : (in_fire & last_i);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end

  assign dout  = buf_q[BUF_W-1 -: OUT_W];
  assign occ_o = cnt_q;
endmodule
